// File: rtl/fetch_pkg.sv
// Shared definitions for the Thumb instruction fetch stage: decode-mode encodings,
// the NOP filler instruction and the fetch FSM state type.
package fetch_pkg;
  localparam logic [1:0]  MODE_STALL  = 2'd0;
  localparam logic [1:0]  MODE_NORMAL = 2'd1;
  localparam logic [1:0]  MODE_BRANCH = 2'd2;
  localparam logic [15:0] THUMB_NOP   = 16'hBF00;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Halfword prefetch FIFO: accepts 0, 1 or 2 halfwords per cycle (d0 first),
// pops one halfword, and flushes to empty in a single cycle.
module fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               push_n,
  input  logic [15:0]              push_d0,
  input  logic [15:0]              push_d1,
  input  logic                     pop,
  output logic [15:0]              head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage carries no reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (!flush && push_n != 2'd0) mem[wr_ptr] <= push_d0;
    if (!flush && push_n == 2'd2) mem[wr_ptr + PW'(1)] <= push_d1;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_n);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + (PW+1)'(push_n) - (PW+1)'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Thumb fetch stage: single-outstanding word fetches split into a halfword FIFO,
// steered by the decode mode. Define FETCH_STATS_EN to add bubble/flush counters.
import fetch_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_mode,
  input  logic [31:0] i_branch_target,
  output logic        o_imem_req_r,
  output logic [31:0] o_imem_addr_r,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [15:0] o_ir_r,
  output logic        o_ir_valid_r,
  output logic [31:0] o_pc_r
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] o_bubble_cnt_r,
  output logic [15:0] o_flush_cnt_r
`endif
);
  localparam int            CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   LIM = (CW+1)'(FIFO_DEPTH - 2);

  fetch_state_t state, state_nxt;
  logic          stale, stale_nxt;
  logic          drop_first;
  logic          pc_load;
  logic          is_normal, is_branch;
  logic          pop, deliver;
  logic [1:0]    push_n;
  logic [15:0]   push_d0, push_d1, head;
  logic [CW-1:0] count;
  logic [CW:0]   count_after;

  assign is_normal = (i_mode == MODE_NORMAL);
  assign is_branch = (i_mode == MODE_BRANCH);
  assign pop       = is_normal && (count != '0);
  assign deliver   = (state == WAIT) && i_imem_rvalid && !stale && !is_branch;
  assign push_n    = deliver ? (drop_first ? 2'd1 : 2'd2) : 2'd0;
  assign push_d0   = drop_first ? i_imem_rdata[31:16] : i_imem_rdata[15:0];
  assign push_d1   = i_imem_rdata[31:16];
  assign count_after = {1'b0, count} + (CW+1)'(push_n) - (CW+1)'(pop);

  // A branch withdraws the request in the same cycle it is seen.
  assign o_imem_req_r = (state == REQ) && !is_branch;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (is_branch),
    .push_n  (push_n),
    .push_d0 (push_d0),
    .push_d1 (push_d1),
    .pop     (pop),
    .head    (head),
    .count   (count)
  );

  always_comb begin
    state_nxt = state;
    stale_nxt = stale;
    case (state)
      IDLE:    if ({1'b0, count} <= LIM) state_nxt = REQ;
      REQ:     if (i_imem_gnt) state_nxt = WAIT;
      WAIT: begin
        if (i_imem_rvalid) begin
          stale_nxt = 1'b0;
          state_nxt = (count_after <= LIM) ? REQ : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // An in-flight word must still be absorbed before re-requesting.
    if (is_branch) begin
      if (state == WAIT && !i_imem_rvalid) begin
        state_nxt = WAIT;
        stale_nxt = 1'b1;
      end else begin
        state_nxt = REQ;
        stale_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      stale         <= 1'b0;
      o_imem_addr_r <= {RESET_PC[31:2], 2'b00};
    end else begin
      state <= state_nxt;
      stale <= stale_nxt;
      if (is_branch)
        o_imem_addr_r <= {i_branch_target[31:2], 2'b00};
      else if (state == REQ && i_imem_gnt)
        o_imem_addr_r <= o_imem_addr_r + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_ir_r       <= THUMB_NOP;
      o_ir_valid_r <= 1'b0;
      o_pc_r       <= RESET_PC;
      pc_load      <= 1'b1;
      drop_first   <= RESET_PC[1];
    end else if (is_branch) begin
      o_ir_r       <= THUMB_NOP;
      o_ir_valid_r <= 1'b0;
      o_pc_r       <= i_branch_target;
      pc_load      <= 1'b1;
      drop_first   <= i_branch_target[1];
    end else begin
      if (pop) begin
        o_ir_r       <= head;
        o_ir_valid_r <= 1'b1;
        o_pc_r       <= pc_load ? o_pc_r : o_pc_r + 32'd2;
        pc_load      <= 1'b0;
      end else if (is_normal) begin
        o_ir_r       <= THUMB_NOP;
        o_ir_valid_r <= 1'b0;
      end
      if (deliver) drop_first <= 1'b0;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_bubble_cnt_r <= '0;
      o_flush_cnt_r  <= '0;
    end else begin
      if (is_normal && count == '0 && o_bubble_cnt_r != '1)
        o_bubble_cnt_r <= o_bubble_cnt_r + 32'd1;
      if (is_branch && o_flush_cnt_r != '1)
        o_flush_cnt_r <= o_flush_cnt_r + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized modes/grants/latencies,
// checked against a halfword-address queue model of the prefetch stream.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_mode;
  logic [31:0] i_branch_target;
  logic        o_imem_req_r;
  logic [31:0] o_imem_addr_r;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [15:0] o_ir_r;
  logic        o_ir_valid_r;
  logic [31:0] o_pc_r;
`ifdef FETCH_STATS_EN
  logic [31:0] o_bubble_cnt_r;
  logic [15:0] o_flush_cnt_r;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_mode          (i_mode),
    .i_branch_target (i_branch_target),
    .o_imem_req_r    (o_imem_req_r),
    .o_imem_addr_r   (o_imem_addr_r),
    .i_imem_gnt      (i_imem_gnt),
    .i_imem_rvalid   (i_imem_rvalid),
    .i_imem_rdata    (i_imem_rdata),
    .o_ir_r          (o_ir_r),
    .o_ir_valid_r    (o_ir_valid_r),
    .o_pc_r          (o_pc_r)
`ifdef FETCH_STATS_EN
    ,
    .o_bubble_cnt_r  (o_bubble_cnt_r),
    .o_flush_cnt_r   (o_flush_cnt_r)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] == 30'd0) return 32'h2105_2003;
    return {a[17:2] ^ 16'hC3C3, a[17:2] ^ 16'h1234};
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Reference: queue of halfword addresses awaiting decode, plus one memory slot.
  logic [31:0] q[$];
  logic [15:0] m_ir;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        need_drop;
  logic [31:0] exp_req_addr;
  bit          pend, pend_stale;
  logic [31:0] pend_addr;
  int          pend_delay;
  int          lat;
  int          m_bubbles, m_flushes;

  task automatic run_cycle(input logic [1:0] mode, input logic [31:0] tgt, input logic gnt);
    logic        rv, hs;
    logic [31:0] hs_addr;
    int          qsz;
    i_mode          = mode;
    i_branch_target = tgt;
    i_imem_gnt      = gnt;
    rv              = pend && (pend_delay == 0);
    i_imem_rvalid   = rv;
    i_imem_rdata    = rv ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    #4;
    hs      = o_imem_req_r && gnt;
    hs_addr = o_imem_addr_r;
    @(posedge clk); #1;
    qsz = q.size();
    if (hs) begin
      chk("req_addr", hs_addr, exp_req_addr);
      chk("one_outstanding", 32'(pend), 32'd0);
      chk("req_space", 32'(qsz <= DEPTH - 2), 32'd1);
    end
    if (mode == MODE_BRANCH) begin
      m_ir = THUMB_NOP; m_valid = 1'b0; m_pc = tgt;
      q.delete();
      need_drop    = tgt[1];
      exp_req_addr = {tgt[31:2], 2'b00};
      if (pend) pend_stale = 1'b1;
      m_flushes++;
    end else if (mode == MODE_NORMAL) begin
      if (qsz != 0) begin
        m_pc = q.pop_front(); m_ir = half_at(m_pc); m_valid = 1'b1;
      end else begin
        m_ir = THUMB_NOP; m_valid = 1'b0;
        m_bubbles++;
      end
    end
    if (rv) begin
      if (mode != MODE_BRANCH && !pend_stale) begin
        if (need_drop) begin
          q.push_back(pend_addr + 32'd2);
          need_drop = 1'b0;
        end else begin
          q.push_back(pend_addr);
          q.push_back(pend_addr + 32'd2);
        end
      end
      pend = 1'b0;
    end else if (pend) begin
      pend_delay--;
    end
    if (hs) begin
      pend = 1'b1; pend_addr = hs_addr; pend_delay = lat - 1; pend_stale = 1'b0;
      exp_req_addr += 32'd4;
    end
    chk("ir", 32'(o_ir_r), 32'(m_ir));
    chk("ir_valid", 32'(o_ir_valid_r), 32'(m_valid));
    chk("pc", o_pc_r, m_pc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held_ir;
    logic [31:0] held_pc, held_addr;
    int          n;
`ifdef FETCH_STATS_EN
    logic [31:0] b0;
    logic [15:0] f0;
`endif
    rst = 1'b1; i_mode = MODE_STALL; i_branch_target = '0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    m_ir = THUMB_NOP; m_valid = 1'b0; m_pc = RESET_PC;
    need_drop = RESET_PC[1]; exp_req_addr = {RESET_PC[31:2], 2'b00};
    pend = 1'b0; pend_stale = 1'b0; pend_addr = '0; pend_delay = 0; lat = 1;
    m_bubbles = 0; m_flushes = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ir", 32'(o_ir_r), 32'(THUMB_NOP));
    chk("rst_valid", 32'(o_ir_valid_r), 32'd0);
    chk("rst_pc", o_pc_r, RESET_PC);
    chk("rst_req", 32'(o_imem_req_r), 32'd0);
    chk("rst_addr", o_imem_addr_r, {RESET_PC[31:2], 2'b00});
`ifdef FETCH_STATS_EN
    chk("rst_bubble", o_bubble_cnt_r, 32'd0);
    chk("rst_flush", 32'(o_flush_cnt_r), 32'd0);
`endif
    rst = 1'b0;

    // Reset release, zero-wait memory
    for (int c = 0; c < 12 && !o_ir_valid_r; c++) run_cycle(MODE_NORMAL, '0, 1'b1);
    chk("t1_ir0", 32'(o_ir_r), 32'h2003);
    chk("t1_pc0", o_pc_r, 32'h0);
    run_cycle(MODE_NORMAL, '0, 1'b1);
    chk("t1_ir1", 32'(o_ir_r), 32'h2105);
    chk("t1_pc1", o_pc_r, 32'h2);

    // Stall with the FIFO filling up
    repeat (8) run_cycle(MODE_STALL, '0, 1'b1);
    held_ir = o_ir_r; held_pc = o_pc_r;
    repeat (5) run_cycle(MODE_STALL, '0, 1'b1);
    chk("t2_hold_ir", 32'(o_ir_r), 32'(held_ir));
    chk("t2_hold_pc", o_pc_r, held_pc);
    chk("t2_req_low", 32'(o_imem_req_r), 32'd0);
    run_cycle(MODE_NORMAL, '0, 1'b1);
    chk("t2_resume_pc", o_pc_r, held_pc + 32'd2);

    // Branch to an odd halfword with a response in flight
    lat = 3;
    for (int c = 0; c < 12 && !pend; c++) run_cycle(MODE_NORMAL, '0, 1'b1);
    run_cycle(MODE_BRANCH, 32'h0000_0102, 1'b1);
    lat = 1;
    for (int c = 0; c < 15 && !o_ir_valid_r; c++) run_cycle(MODE_NORMAL, '0, 1'b1);
    chk("t3_ir", 32'(o_ir_r), 32'(half_at(32'h102)));
    chk("t3_pc", o_pc_r, 32'h102);

    // Grant withheld: request and address must hold while the FIFO drains
    repeat (10) run_cycle(MODE_NORMAL, '0, 1'b0);
    held_addr = o_imem_addr_r;
    for (int c = 0; c < 4; c++) begin
      run_cycle(MODE_NORMAL, '0, 1'b0);
      chk("t4_req", 32'(o_imem_req_r), 32'd1);
      chk("t4_addr", o_imem_addr_r, held_addr);
    end
    chk("t4_ir_nop", 32'(o_ir_r), 32'(THUMB_NOP));
    chk("t4_valid", 32'(o_ir_valid_r), 32'd0);

    // Redirect latency with nothing outstanding
    run_cycle(MODE_BRANCH, 32'h0000_0200, 1'b0);
    n = 0;
    while (n < 10 && !o_ir_valid_r) begin
      run_cycle(MODE_NORMAL, '0, 1'b1);
      n++;
    end
    chk("t4_latency", 32'(n), 32'd3);

    // Branch coinciding with rvalid and gnt
    for (int c = 0; c < 10 && !(pend && pend_delay == 0); c++) run_cycle(MODE_NORMAL, '0, 1'b1);
    run_cycle(MODE_BRANCH, 32'h0000_0300, 1'b1);
    chk("t5_addr", o_imem_addr_r, 32'h300);
    repeat (6) run_cycle(MODE_NORMAL, '0, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      int          r;
      logic [1:0]  md;
      logic [31:0] tgt;
      r   = int'($urandom_range(0, 99));
      md  = (r < 60) ? MODE_NORMAL : (r < 72) ? MODE_STALL : (r < 80) ? 2'd3 : MODE_BRANCH;
      tgt = 32'($urandom_range(0, 1023)) & 32'h0000_03FE;
      lat = int'($urandom_range(1, 3));
      run_cycle(md, tgt, $urandom_range(0, 99) < 70);
    end

`ifdef FETCH_STATS_EN
    chk("stat_bubble_total", o_bubble_cnt_r, 32'(m_bubbles));
    chk("stat_flush_total", 32'(o_flush_cnt_r), 32'(m_flushes));
    b0 = o_bubble_cnt_r; f0 = o_flush_cnt_r;
    run_cycle(MODE_BRANCH, 32'h0000_0400, 1'b0);
    run_cycle(MODE_BRANCH, 32'h0000_0400, 1'b0);
    repeat (3) run_cycle(MODE_NORMAL, '0, 1'b0);
    chk("stat_bubble_delta", o_bubble_cnt_r - b0, 32'd3);
    chk("stat_flush_delta", 32'(o_flush_cnt_r - f0), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
